// File: rtl/parity_frame_engine.sv
// parity_frame_engine
//   Folds WIDTH-bit beats from a valid/ready stream into one running parity bit.
//   Emits one registered parity/error result per frame on a second valid/ready port.
//   A frame is FRAME_LEN beats, or fewer when in_last is set on an accepted beat.
//   Parity sense (odd_mode) and mode (chk_mode) are latched on the first beat of each frame.
//   Optional feature: define PARITY_STATS_EN to add the saturating frame_cnt/err_cnt ports.
module parity_frame_engine #(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 4,
  localparam int CW        = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_par,
  input  logic             odd_mode,
  input  logic             chk_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CW-1:0]    out_beats
`ifdef PARITY_STATS_EN
  ,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          acc;
  logic [CW-1:0] cnt;
  logic          odd_l;
  logic          chk_l;

  logic          accept;
  logic          final_beat;
  logic          out_fire;
  logic          beat_par;
  logic          acc_base;
  logic          frame_odd;
  logic          frame_chk;
  logic          par_next;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake decode, next-state logic and the parity of the current beat.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = (state != HOLD) && !rst;
    accept     = in_valid && in_ready;
    final_beat = accept && (in_last || (cnt == LAST_CNT));
    out_fire   = out_valid && out_ready;

    // On the first beat the mode inputs are used directly; afterwards the
    // latched copies, so mid-frame mode changes have no effect.
    frame_odd  = (state == IDLE) ? odd_mode : odd_l;
    frame_chk  = (state == IDLE) ? chk_mode : chk_l;
    acc_base   = (state == IDLE) ? 1'b0 : acc;
    beat_par   = ^in_data;
    par_next   = acc_base ^ beat_par ^ frame_odd;

    case (state)
      IDLE: begin
        if (final_beat) begin
          state_next = HOLD;
        end else if (accept) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (final_beat) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, beat counter, latched modes and the registered result.
  // NOTE: reset is synchronous; every register here is cleared so a reset
  // mid-frame discards the partial frame completely.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= 1'b0;
      cnt        <= '0;
      odd_l      <= 1'b0;
      chk_l      <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
      out_beats  <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) begin
          odd_l <= odd_mode;
          chk_l <= chk_mode;
        end
        if (final_beat) begin
          acc        <= 1'b0;
          cnt        <= '0;
          out_parity <= par_next;
          out_err    <= frame_chk & (par_next != in_par);
          out_beats  <= cnt + 1'b1;
        end else begin
          acc <= acc_base ^ beat_par;
          cnt <= cnt + 1'b1;
        end
      end

      // A final beat can only arrive outside HOLD, so it never overlaps a handshake.
      if (final_beat) begin
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_STATS_EN
  // Saturating counters of delivered frames and of delivered error frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (out_fire) begin
      if (frame_cnt != 8'hFF) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (out_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_engine.sv
// tb_parity_frame_engine
//   Table of directed frames, hand-written reset sequences, then random frames
//   checked against a bit-counting reference model.
module tb_parity_frame_engine;

  localparam int WIDTH     = 8;
  localparam int FRAME_LEN = 4;
  localparam int CW        = $clog2(FRAME_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_par;
  logic             odd_mode;
  logic             chk_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_err;
  logic [CW-1:0]    out_beats;
`ifdef PARITY_STATS_EN
  logic [7:0]       frame_cnt;
  logic [7:0]       err_cnt;
  int               exp_frames = 0;
  int               exp_errs   = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parity_frame_engine #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_par    (in_par),
    .odd_mode  (odd_mode),
    .chk_mode  (chk_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_parity(out_parity),
    .out_err   (out_err),
    .out_beats (out_beats)
`ifdef PARITY_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [3:0][7:0] d;
    int              n;
    logic            last;
    logic            odd;
    logic            chk;
    logic            par;
    bit              scramble;
    int              hold;
    logic            ep;
    logic            ee;
    int              eb;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: parity of all bits in the frame, inverted in odd mode.
  function automatic logic model_parity(input logic [3:0][7:0] d, input int n, input logic odd);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += $countones(d[i]);
    return ((ones % 2) == 1) ^ odd;
  endfunction

  // Sends one frame, optionally with idle gaps and mid-frame mode noise,
  // stalls the result for 'hold' cycles, then completes the handshake.
  task automatic run_frame(input string tag, input vec_t v, input bit gaps);
    for (int i = 0; i < v.n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = v.d[i];
      in_last  = (i == v.n - 1) ? v.last : 1'b0;
      if (i == 0 || !v.scramble) begin
        odd_mode = v.odd;
        chk_mode = v.chk;
        in_par   = v.par;
      end else begin
        odd_mode = 1'($urandom_range(0, 1));
        chk_mode = 1'($urandom_range(0, 1));
        in_par   = 1'($urandom_range(0, 1));
      end
      if (i == v.n - 1) in_par = v.par;
      begin
        int w = 0;
        while (!in_ready && w < 20) begin
          tick();
          w++;
        end
        if (!in_ready) check({tag, " in_ready wait"}, 32'(in_ready), 32'd1);
      end
      check({tag, " no early valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " out_valid"},  32'(out_valid),  32'd1);
    check({tag, " out_parity"}, 32'(out_parity), 32'(v.ep));
    check({tag, " out_err"},    32'(out_err),    32'(v.ee));
    check({tag, " out_beats"},  32'(out_beats),  32'(v.eb));

    for (int h = 0; h < v.hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_last   = 1'($urandom_range(0, 1));
      tick();
      check({tag, " hold {valid,ready,par,err,beats}"},
            32'({out_valid, in_ready, out_parity, out_err, out_beats}),
            32'({1'b1, 1'b0, v.ep, v.ee, CW'(v.eb)}));
    end

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    check({tag, " in_ready in handshake"}, 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    check({tag, " after handshake {valid,ready}"}, 32'({out_valid, in_ready}), 32'b01);
`ifdef PARITY_STATS_EN
    if (exp_frames < 255) exp_frames++;
    if (v.ee && exp_errs < 255) exp_errs++;
    check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({tag, " err_cnt"},   32'(err_cnt),   32'(exp_errs));
`endif
  endtask

  function automatic vec_t mk(input logic [3:0][7:0] d, input int n, input logic last,
                              input logic odd, input logic chk, input logic par,
                              input bit scr, input int hold,
                              input logic ep, input logic ee, input int eb);
    vec_t v;
    v.d = d; v.n = n; v.last = last; v.odd = odd; v.chk = chk; v.par = par;
    v.scramble = scr; v.hold = hold; v.ep = ep; v.ee = ee; v.eb = eb;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_par = 1'b0;
    odd_mode = 1'b0; chk_mode = 1'b0; out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset {valid,par,err,beats}", 32'({out_valid, out_parity, out_err, out_beats}), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Directed frames: data, n, last, odd, chk, par, scramble, hold, parity, err, beats.
    tbl.push_back(mk({8'hFF, 8'h00, 8'h03, 8'h01}, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 4));
    tbl.push_back(mk({8'hFF, 8'h00, 8'h03, 8'h01}, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 4));
    tbl.push_back(mk({8'hFF, 8'h00, 8'h03, 8'h01}, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 4));
    tbl.push_back(mk({8'h00, 8'h00, 8'h00, 8'h07}, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 2));
    tbl.push_back(mk({8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1));
    tbl.push_back(mk({8'h0F, 8'h0F, 8'h0F, 8'h0F}, 4, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 4));
    tbl.push_back(mk({8'h0F, 8'h0F, 8'h0F, 8'h0F}, 4, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5, 1'b0, 1'b0, 4));
    tbl.push_back(mk({8'h01, 8'h01, 8'h01, 8'h01}, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 4));
    tbl.push_back(mk({8'h00, 8'h00, 8'h00, 8'h80}, 1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1));
    tbl.push_back(mk({8'h00, 8'h00, 8'h00, 8'h80}, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1'b1, 1'b1, 1));
    foreach (tbl[k]) run_frame($sformatf("vec%0d", k), tbl[k], 1'b0);

    // Reset mid-frame: two beats with odd parity are taken, then discarded.
    in_valid = 1'b1; in_data = 8'h01; odd_mode = 1'b0; chk_mode = 1'b0; in_last = 1'b0;
    tick();
    in_data = 8'h00;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid rst in_ready", 32'(in_ready), 32'd0);
    tick();
    check("mid rst {valid,par,err,beats}", 32'({out_valid, out_parity, out_err, out_beats}), 32'd0);
    rst = 1'b0;
    #1;
    check("mid rst in_ready after", 32'(in_ready), 32'd1);
`ifdef PARITY_STATS_EN
    check("mid rst frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid rst err_cnt",   32'(err_cnt),   32'd0);
    exp_frames = 0;
    exp_errs   = 0;
`endif
    run_frame("after rst", mk({8'h01, 8'h01, 8'h01, 8'h01}, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 4), 1'b0);

    // Random frames against the reference model.
    for (int r = 0; r < 300; r++) begin
      logic [3:0][7:0] d;
      int   n;
      logic odd, chk, par, ep;
      d   = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      n   = $urandom_range(1, FRAME_LEN);
      odd = 1'($urandom_range(0, 1));
      chk = 1'($urandom_range(0, 1));
      par = 1'($urandom_range(0, 1));
      ep  = model_parity(d, n, odd);
      v   = mk(d, n, (n < FRAME_LEN) ? 1'b1 : 1'($urandom_range(0, 1)), odd, chk, par,
               1, $urandom_range(0, 3), ep, chk & (ep != par), n);
      run_frame($sformatf("rnd%0d", r), v, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
